ir_encoder_loader: RTL and testbench

- Inverse of the instruction-field segmenter: packs decoded fields (rd, rs, rt, func, imm, offset) plus a 4-bit opcode into 16-bit instruction words.
- Writes the packed words sequentially into instruction memory.
- Sits between the testbench/boot program source and the instruction memory write port.
- Input is a valid/ready stream; a small FSM drives the memory write side and tracks address, word count, completion and errors.

---
 rtl/ir_encoder_loader_pkg.sv | 26 ++
 rtl/ir_encoder_loader_if.sv | 30 +++
 rtl/ir_encoder_loader_packer.sv | 26 ++
 rtl/ir_encoder_loader.sv | 108 ++++++++++
 tb/tb_ir_encoder_loader.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ir_encoder_loader_pkg.sv
// Shared types and field widths for the instruction encoder/loader.
// Imported by the interface, the field packer and the loader top.
package ir_encoder_loader_pkg;

  localparam int REG_W  = 3;
  localparam int FUNC_W = 3;
  localparam int IMM_W  = 6;
  localparam int OFF_W  = 9;
  localparam int BODY_W = 12;
  localparam int OP_W   = 4;

  typedef enum logic [1:0] {
    R_TYPE   = 2'b00,
    I_TYPE   = 2'b01,
    J_TYPE   = 2'b10,
    BAD_TYPE = 2'b11
  } ir_type_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCEPT = 2'b01,
    S_WRITE  = 2'b10,
    S_DONE   = 2'b11
  } state_e;

endpackage

// File: rtl/ir_encoder_loader_if.sv
// Field-record stream into the loader (valid/ready handshake).
// master = record source, slave = loader.
interface ir_encoder_loader_if;
  import ir_encoder_loader_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [1:0]        ir_type;
  logic [OP_W-1:0]   opcode;
  logic [REG_W-1:0]  rd;
  logic [REG_W-1:0]  rs;
  logic [REG_W-1:0]  rt;
  logic [FUNC_W-1:0] func;
  logic [IMM_W-1:0]  imm;
  logic [OFF_W-1:0]  offset;

  modport master (
    output in_valid, in_last, ir_type, opcode,
    output rd, rs, rt, func, imm, offset,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, ir_type, opcode,
    input  rd, rs, rt, func, imm, offset,
    output in_ready
  );

endinterface

// File: rtl/ir_encoder_loader_packer.sv
// Packs decoded fields into the 12-bit instruction body.
// Inverse of the field segmenter; invalid type yields zero.
module ir_field_packer
  import ir_encoder_loader_pkg::*;
(
  input  logic [1:0]        ir_type,
  input  logic [REG_W-1:0]  rd,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [FUNC_W-1:0] func,
  input  logic [IMM_W-1:0]  imm,
  input  logic [OFF_W-1:0]  offset,
  output logic [BODY_W-1:0] body
);

  always_comb begin
    body = '0;
    unique case (ir_type)
      R_TYPE:  body = {rd, rs, rt, func};
      I_TYPE:  body = {rs, rt, imm};
      J_TYPE:  body = {offset, func};
      default: body = '0;
    endcase
  end

endmodule

// File: rtl/ir_encoder_loader.sv
// Sequential instruction-memory loader: packs field records into
// 16-bit words and writes them from BASE_ADDR upward, one per 2 cycles.
module ir_encoder_loader
  import ir_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  ir_encoder_loader_if.slave src,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   MAXW = (ADDR_W+1)'(MAX_WORDS);

  state_e              state;
  logic                we_q;
  logic                last_q;
  logic [ADDR_W-1:0]   ptr;
  logic [BODY_W-1:0]   body;
  logic [ADDR_W:0]     wc_nxt;
  logic                hs;

  ir_field_packer u_pack (
    .ir_type (src.ir_type),
    .rd      (src.rd),
    .rs      (src.rs),
    .rt      (src.rt),
    .func    (src.func),
    .imm     (src.imm),
    .offset  (src.offset),
    .body    (body)
  );

  assign src.in_ready = (state == S_ACCEPT);
  assign hs     = src.in_valid && src.in_ready;
  assign wc_nxt = word_count + (ADDR_W+1)'(1);

  // Strobe is masked while reset is held so a session cut
  // mid-write never reaches memory.
  assign mem_we = we_q & ~reset;
  assign done   = (state == S_DONE);
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      last_q     <= 1'b0;
      ptr        <= BASE;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      err        <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            ptr        <= BASE;
            word_count <= '0;
            err        <= 1'b0;
            state      <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (hs) begin
            if (src.ir_type == BAD_TYPE) begin
              err <= 1'b1;
              if (src.in_last) state <= S_DONE;
            end else begin
              mem_addr  <= ptr;
              mem_wdata <= {src.opcode, body};
              last_q    <= src.in_last;
              we_q      <= 1'b1;
              state     <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          we_q       <= 1'b0;
          ptr        <= ptr + ADDR_W'(1);
          word_count <= wc_nxt;
          if (last_q) begin
            state <= S_DONE;
          end else if (wc_nxt == MAXW) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_ACCEPT;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_encoder_loader.sv
// Self-checking bench for ir_encoder_loader: directed sessions plus
// randomized sessions checked against a record-level reference model.
module tb_ir_encoder_loader;

  localparam int AW   = 4;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic reset;
  logic start;
  always #5 clk = ~clk;

  ir_encoder_loader_if bus ();

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [AW:0]   word_count;
  logic          busy, done, err;

  ir_encoder_loader #(
    .ADDR_W    (AW),
    .BASE_ADDR (0),
    .MAX_WORDS (MAXW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src        (bus.slave),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    int typ; int op; int rd; int rs; int rt;
    int fn; int imm; int off; bit last;
  } rec_t;

  int   checks = 0;
  int   failures = 0;
  rec_t recs[$];
  int   got_data[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_word(input rec_t r);
    int b;
    case (r.typ)
      0: b = r.rd * 512 + r.rs * 64 + r.rt * 8 + r.fn;
      1: b = r.rs * 512 + r.rt * 64 + r.imm;
      2: b = r.off * 8 + r.fn;
      default: b = 0;
    endcase
    return r.op * 4096 + b;
  endfunction

  function automatic rec_t mk(input int typ, input int op, input int rd,
                              input int rs, input int rt, input int fn,
                              input int imm, input int off, input bit last);
    rec_t r;
    r.typ = typ; r.op = op; r.rd = rd; r.rs = rs; r.rt = rt;
    r.fn = fn; r.imm = imm; r.off = off; r.last = last;
    return r;
  endfunction

  function automatic rec_t rnd_rec(input bit last);
    rec_t r;
    r.typ = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
    r.op  = $urandom_range(0, 15);
    r.rd  = $urandom_range(0, 7);
    r.rs  = $urandom_range(0, 7);
    r.rt  = $urandom_range(0, 7);
    r.fn  = $urandom_range(0, 7);
    r.imm = $urandom_range(0, 63);
    r.off = $urandom_range(0, 511);
    r.last = last;
    return r;
  endfunction

  task automatic drive(input rec_t r, input bit v);
    bus.in_valid = v;
    bus.in_last  = r.last;
    bus.ir_type  = 2'(r.typ);
    bus.opcode   = 4'(r.op);
    bus.rd       = 3'(r.rd);
    bus.rs       = 3'(r.rs);
    bus.rt       = 3'(r.rt);
    bus.func     = 3'(r.fn);
    bus.imm      = 6'(r.imm);
    bus.offset   = 9'(r.off);
  endtask

  task automatic run_session(input bit gaps);
    int exp_addr[$];
    int exp_data[$];
    int got_addr[$];
    int ptr, cnt, acc, i, cyc, prev_we, done_cyc;
    bit e_err, ended, end_write, fin, any_bad, hs;
    rec_t idle_r;

    // Reference: walk the records as a session would consume them.
    ptr = 0; cnt = 0; acc = 0; e_err = 0; ended = 0;
    end_write = 0; any_bad = 0;
    foreach (recs[k]) begin
      if (!ended) begin
        acc++;
        if (recs[k].typ == 3) begin
          any_bad = 1; e_err = 1;
          if (recs[k].last) begin ended = 1; end_write = 0; end
        end else begin
          exp_addr.push_back(ptr % (1 << AW));
          exp_data.push_back(model_word(recs[k]));
          ptr++; cnt++;
          if (recs[k].last) begin
            ended = 1; end_write = 1;
          end else if (cnt == MAXW) begin
            ended = 1; end_write = 1; e_err = 1;
          end
        end
      end
    end

    got_data.delete();
    idle_r = rnd_rec(0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_cleared", err, 0);

    i = 0; cyc = 0; fin = 0; prev_we = -1; done_cyc = 0;
    while (!fin && cyc < 300) begin
      if (i < recs.size() && (!gaps || $urandom_range(0, 2) != 0))
        drive(recs[i], 1'b1);
      else
        drive(idle_r, 1'b0);
      hs = bus.in_valid && bus.in_ready;
      if (mem_we) begin
        got_addr.push_back(int'(mem_addr));
        got_data.push_back(int'(mem_wdata));
        chk("ready_low_in_write", bus.in_ready, 0);
        if (!gaps && !any_bad && prev_we >= 0)
          chk("write_spacing", cyc - prev_we, 2);
        prev_we = cyc;
      end else if (got_data.size() > 0) begin
        chk("addr_hold", mem_addr, got_addr[$]);
        chk("wdata_hold", mem_wdata, got_data[$]);
      end
      if (done) begin
        fin = 1; done_cyc = cyc;
      end
      if (hs) i++;
      if (!fin) begin
        @(posedge clk); #1;
        cyc++;
      end
    end

    chk("session_ends", fin, 1);
    if (fin) begin
      chk("n_writes", got_data.size(), exp_data.size());
      foreach (exp_data[k]) begin
        if (k < got_data.size()) begin
          chk("w_addr", got_addr[k], exp_addr[k]);
          chk("w_data", got_data[k], exp_data[k]);
        end
      end
      chk("accepted", i, acc);
      chk("err_at_done", err, e_err);
      chk("wc_at_done", word_count, cnt);
      chk("ready_at_done", bus.in_ready, 0);
      if (end_write) chk("done_latency", done_cyc - prev_we, 1);
      @(posedge clk); #1;
      chk("done_pulse", done, 0);
      chk("busy_idle", busy, 0);
      chk("wc_hold", word_count, cnt);
      chk("err_sticky", err, e_err);
    end
    drive(idle_r, 1'b0);
    recs.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_wc"}, word_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_ready"}, bus.in_ready, 0);
  endtask

  initial begin
    rec_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    start = 1'b0;
    drive(z, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    recs.push_back(mk(0, 3, 5, 2, 7, 1, 0, 0, 1));
    run_session(0);
    chk("r_word", got_data.size() > 0 ? got_data[0] : -1, 32'h3AB9);

    recs.push_back(mk(1, 1, 0, 4, 3, 0, 'h2D, 0, 1));
    run_session(0);
    chk("i_word", got_data.size() > 0 ? got_data[0] : -1, 32'h18ED);

    recs.push_back(mk(2, 15, 0, 0, 0, 6, 0, 'h1A5, 1));
    run_session(0);
    chk("j_word", got_data.size() > 0 ? got_data[0] : -1, 32'hFD2E);

    for (int k = 0; k < 3; k++) recs.push_back(rnd_rec(k == 2 ? 1'b1 : 1'b0));
    foreach (recs[k]) if (recs[k].typ == 3) recs[k].typ = k % 3;
    run_session(0);

    recs.push_back(mk(0, 2, 1, 1, 1, 1, 0, 0, 0));
    recs.push_back(mk(3, 9, 7, 7, 7, 7, 63, 511, 0));
    recs.push_back(mk(1, 4, 0, 6, 5, 0, 17, 0, 1));
    run_session(0);

    recs.push_back(mk(0, 5, 3, 3, 3, 3, 0, 0, 0));
    recs.push_back(mk(3, 5, 3, 3, 3, 3, 0, 0, 1));
    run_session(1);

    for (int k = 0; k < 6; k++) begin
      recs.push_back(rnd_rec(0));
      recs[k].typ = k % 3;
    end
    run_session(0);

    // Reset while the write strobe is up.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drive(mk(0, 7, 7, 7, 7, 7, 0, 0, 1), 1'b1);
    @(posedge clk); #1;
    drive(z, 1'b0);
    chk("pre_reset_we", mem_we, 1);
    reset = 1'b1;
    #1;
    chk("we_masked_in_reset", mem_we, 0);
    @(posedge clk); #1;
    chk_all_zero("midreset");
    reset = 1'b0;
    @(posedge clk); #1;
    recs.push_back(mk(2, 6, 0, 0, 0, 2, 0, 300, 1));
    run_session(0);

    for (int s = 0; s < 20; s++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) recs.push_back(rnd_rec(k == n - 1));
      run_session(s[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
